fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//  IF stage: holds the PC, drives the instruction-memory address and registers the fetched word into the IF/ID pipe regs read by decode.
//  Predicts next PC (BTB + 2-bit BHT) and applies redirects from execute (mispredict) and from the CSR unit (ecall/mret trap).
//  Honours decode-side keep (stall) and nop (flush) controls.
// PARAMETERS
//  RESET_PC    32'h0000_0000  PC loaded on reset
//  BP_IDX_W    6              predictor index width; 2**BP_IDX_W BHT/BTB entries, index = pc[BP_IDX_W+1:2]
// PORTS
//  clk                 in   1   single clock, rising edge
//  rst                 in   1   asynchronous, active-high reset
//  keep                in   1   stall: hold PC and IF/ID regs
//  nop                 in   1   flush IF/ID regs to bubble (PC still advances unless keep)
//  trap_redirect       in   1   CSR trap/mret redirect request
//  trap_pc             in   32  target for trap_redirect (mtvec / mepc)
//  br_redirect         in   1   execute detected mispredict
//  br_pc               in   32  correct next PC for br_redirect
//  upd_valid           in   1   execute resolved a conditional branch / jal
//  upd_pc              in   32  PC of resolved instruction
//  upd_taken           in   1   resolved direction
//  upd_target          in   32  resolved taken target
//  imem_addr           out  32  instruction address (= current PC)
//  imem_rdata          in   32  instruction word, combinational, same cycle
//  PC_pype0            out  32  PC of instruction in IF/ID
//  PCp4_pype0          out  32  PC+4 of that instruction
//  Instraction_pype    out  32  fetched instruction
//  is_branch_predict   out  1   fetch predicted taken for that instruction
//  PC_Np_pype0         out  32  predicted next PC for that instruction
// BEHAVIOUR
//  Reset (async, rst=1): pc<=RESET_PC; PC_pype0,PCp4_pype0,PC_Np_pype0<=0; Instraction_pype<=32'h0000_0013 (addi x0,x0,0); is_branch_predict<=0;
//   all BHT counters<=2'b01 (weakly not-taken); all BTB valid<=0. Reset mid-fetch discards everything; first fetch after release from RESET_PC.
//  Latency: word at imem_addr in cycle N appears on IF/ID outputs in cycle N+1.
//  Next-PC priority per edge: trap_redirect > br_redirect > keep > prediction.
//   trap: pc<=trap_pc; br: pc<=br_pc; keep: pc held; else pc<=pred_npc.
//  IF/ID update priority: (trap_redirect|br_redirect|nop) -> bubble (inst=0x13, is_branch_predict=0, PCs=0);
//   else keep -> hold all; else load {pc, pc+4, imem_rdata, pred_taken, pred_npc}.
//  Redirect while keep=1: redirect wins; PC loads target, IF/ID flushed.
//  Prediction: hit = btb_valid[i] & btb_tag[i]==pc[31:BP_IDX_W+2]; pred_taken = hit & bht[i][1];
//   pred_npc = pred_taken ? btb_target[i] : pc+4.
//  Update on upd_valid (independent of keep/nop/redirect): bht saturating +1 if taken, -1 if not (clamp 2'b00/2'b11);
//   if upd_taken: btb entry <= {valid=1, tag, upd_target}. Not-taken never invalidates BTB.
//  Same-cycle lookup and update of same index: lookup sees old value (read-before-write).
//  Arithmetic: pc+4 is 32-bit, wraps 32'hFFFF_FFFC -> 32'h0000_0000; pc[1:0] forced 2'b00 on all loads.
// CONFIGURATION
//  FETCH_BPRED_EN defined: BTB/BHT present as above.
//  Not defined: no predictor storage; pred_taken=0, pred_npc=pc+4 always; upd_* ignored; is_branch_predict always 0.
// STRUCTURE
//  define.v gains: `NOP_INST 32'h0000_0013, `RESET_PC_DEF, BHT state encodings (SNT/WNT/WT/ST).
//  Sub-module branch_predictor (BHT+BTB, lookup + update ports), instantiated only under FETCH_BPRED_EN.
//  fetch_stage keeps PC reg, next-PC mux, IF/ID regs.
// TESTING
//  Reset release, imem returns sequential addi words -> imem_addr 0,4,8; IF/ID PC 0 then 4, PCp4_pype0=PC+4.
//  keep=1 two cycles at PC=0x10 -> imem_addr stays 0x10, IF/ID outputs unchanged; resumes 0x14 after.
//  br_redirect=1,br_pc=0x200 with keep=1 -> next imem_addr 0x200, Instraction_pype=0x13, is_branch_predict=0.
//  trap_redirect(0x80) and br_redirect(0x200) same cycle -> pc=0x80.
//  FETCH_BPRED_EN: two upd_taken for pc=0x40 target 0x100 -> next fetch of 0x40 gives is_branch_predict=1, PC_Np_pype0=0x100; without macro: 0, 0x44.
//  rst asserted mid-stream at pc=0x30 -> outputs reset same cycle, fetch restarts RESET_PC, prior BTB training lost.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// -----------------------------------------------------------------------------
// fetch_stage_pkg
//  Shared constants and types for the IF stage and its branch predictor.
//  Contents:
//   NOP_INST      canonical bubble instruction (addi x0,x0,0)
//   RESET_PC_DEF  default reset program counter
//   bht_state_t   2-bit branch history counter encodings (SNT/WNT/WT/ST)
//   bht_next()    saturating counter update
// -----------------------------------------------------------------------------
package fetch_stage_pkg;

    localparam logic [31:0] NOP_INST     = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

    typedef enum logic [1:0] {
        SNT = 2'b00,   // strongly not-taken
        WNT = 2'b01,   // weakly not-taken (reset state)
        WT  = 2'b10,   // weakly taken
        ST  = 2'b11    // strongly taken
    } bht_state_t;

    // Saturating increment on taken, decrement on not-taken.
    function automatic bht_state_t bht_next(input bht_state_t cur, input logic taken);
        bht_state_t res;
        res = cur;
        if (taken) begin
            if (cur != ST) res = bht_state_t'(cur + 2'd1);
        end else begin
            if (cur != SNT) res = bht_state_t'(cur - 2'd1);
        end
        return res;
    endfunction

endpackage

// File: rtl/fetch_stage_branch_predictor.sv
// -----------------------------------------------------------------------------
// fetch_stage_branch_predictor
//  Direct-mapped BTB plus 2-bit BHT, 2**IDX_W entries, indexed by pc[IDX_W+1:2].
//  Lookup is combinational from the stored state, so a same-cycle update of
//  the looked-up entry is only visible from the next cycle on.
//  Ports:
//   clk, rst         clock, asynchronous active-high reset
//   lookup_pc        PC being fetched
//   pred_taken       BTB hit and counter predicts taken
//   pred_npc         predicted next PC (target or lookup_pc+4)
//   upd_valid        a resolved branch/jal is being reported
//   upd_pc           PC of the resolved instruction
//   upd_taken        resolved direction
//   upd_target       resolved taken target
// -----------------------------------------------------------------------------
module fetch_stage_branch_predictor
    import fetch_stage_pkg::*;
#(
    parameter int IDX_W = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] lookup_pc,
    output logic        pred_taken,
    output logic [31:0] pred_npc,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target
);

    localparam int N     = 1 << IDX_W;
    localparam int TAG_W = 30 - IDX_W;

    logic [IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0] lk_tag;
    logic [IDX_W-1:0] upd_idx;
    logic [TAG_W-1:0] upd_tag;

    assign lk_idx  = lookup_pc[IDX_W+1:2];
    assign lk_tag  = lookup_pc[31:IDX_W+2];
    assign upd_idx = upd_pc[IDX_W+1:2];
    assign upd_tag = upd_pc[31:IDX_W+2];

    // Word-aligned addresses: the low two bits carry no information here.
    logic unused_low_bits;
    assign unused_low_bits = ^{upd_pc[1:0], upd_target[1:0]};

    logic [1:0]       bht_q   [N];
    logic             valid_q [N];
    logic [TAG_W-1:0] tag_q   [N];
    logic [29:0]      tgt_q   [N];

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_entry
            bht_state_t       cnt_reg;
            logic             valid_reg;
            logic [TAG_W-1:0] tag_reg;
            logic [29:0]      tgt_reg;
            logic             sel;

            assign sel = upd_valid && (upd_idx == IDX_W'(gi));

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cnt_reg   <= WNT;
                    valid_reg <= 1'b0;
                    tag_reg   <= '0;
                    tgt_reg   <= '0;
                end else if (sel) begin
                    cnt_reg <= bht_next(cnt_reg, upd_taken);
                    // A not-taken outcome leaves the BTB entry alone.
                    if (upd_taken) begin
                        valid_reg <= 1'b1;
                        tag_reg   <= upd_tag;
                        tgt_reg   <= upd_target[31:2];
                    end
                end
            end

            assign bht_q[gi]   = cnt_reg;
            assign valid_q[gi] = valid_reg;
            assign tag_q[gi]   = tag_reg;
            assign tgt_q[gi]   = tgt_reg;
        end
    endgenerate

    logic       hit;
    logic [1:0] lk_cnt;

    assign lk_cnt     = bht_q[lk_idx];
    assign hit        = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign pred_taken = hit && lk_cnt[1];
    assign pred_npc   = pred_taken ? {tgt_q[lk_idx], 2'b00} : (lookup_pc + 32'd4);

endmodule

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//  IF stage: PC register, next-PC selection and IF/ID pipeline registers.
//  Instruction memory is read combinationally at imem_addr; the word is
//  registered into IF/ID on the following edge.
//  Next PC priority: trap_redirect > br_redirect > keep > prediction.
//  Build option: FETCH_BPRED_EN instantiates the BTB/BHT predictor; without it
//  the stage always predicts pc+4 and ignores the upd_* inputs.
//  Ports:
//   clk, rst            clock, asynchronous active-high reset
//   keep                stall: hold PC and IF/ID
//   nop                 flush IF/ID to a bubble (PC still advances)
//   trap_redirect/pc    CSR trap or mret redirect
//   br_redirect/br_pc   execute mispredict redirect
//   upd_*               predictor training from execute
//   imem_addr/rdata     instruction memory interface
//   PC_pype0, PCp4_pype0, Instraction_pype, is_branch_predict, PC_Np_pype0
//                       IF/ID register outputs read by decode
// -----------------------------------------------------------------------------
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter int          BP_IDX_W = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        keep,
    input  logic        nop,
    input  logic        trap_redirect,
    input  logic [31:0] trap_pc,
    input  logic        br_redirect,
    input  logic [31:0] br_pc,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] PC_pype0,
    output logic [31:0] PCp4_pype0,
    output logic [31:0] Instraction_pype,
    output logic        is_branch_predict,
    output logic [31:0] PC_Np_pype0
);

    logic [31:0] pc_reg;
    logic [31:0] pc_next;
    logic [31:0] pc_plus4;
    logic        pred_taken;
    logic [31:0] pred_npc;

    assign pc_plus4  = pc_reg + 32'd4;
    assign imem_addr = pc_reg;

`ifdef FETCH_BPRED_EN
    fetch_stage_branch_predictor #(
        .IDX_W      (BP_IDX_W)
    ) u_bpred (
        .clk        (clk),
        .rst        (rst),
        .lookup_pc  (pc_reg),
        .pred_taken (pred_taken),
        .pred_npc   (pred_npc),
        .upd_valid  (upd_valid),
        .upd_pc     (upd_pc),
        .upd_taken  (upd_taken),
        .upd_target (upd_target)
    );
`else
    localparam int unused_bp_idx_w = BP_IDX_W;
    logic unused_upd;
    assign unused_upd = ^{upd_valid, upd_pc, upd_taken, upd_target};
    assign pred_taken = 1'b0;
    assign pred_npc   = pc_plus4;
`endif

    always_comb begin
        pc_next = pc_reg;
        if (trap_redirect)    pc_next = {trap_pc[31:2], 2'b00};
        else if (br_redirect) pc_next = {br_pc[31:2], 2'b00};
        else if (keep)        pc_next = pc_reg;
        else                  pc_next = {pred_npc[31:2], 2'b00};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) pc_reg <= {RESET_PC[31:2], 2'b00};
        else     pc_reg <= pc_next;
    end

    // A redirect kills the instruction currently being fetched, even when
    // decode is stalling, so it takes precedence over keep.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            PC_pype0          <= '0;
            PCp4_pype0        <= '0;
            Instraction_pype  <= NOP_INST;
            is_branch_predict <= 1'b0;
            PC_Np_pype0       <= '0;
        end else if (trap_redirect || br_redirect || nop) begin
            PC_pype0          <= '0;
            PCp4_pype0        <= '0;
            Instraction_pype  <= NOP_INST;
            is_branch_predict <= 1'b0;
            PC_Np_pype0       <= '0;
        end else if (!keep) begin
            PC_pype0          <= pc_reg;
            PCp4_pype0        <= pc_plus4;
            Instraction_pype  <= imem_rdata;
            is_branch_predict <= pred_taken;
            PC_Np_pype0       <= {pred_npc[31:2], 2'b00};
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        keep, nop, trap_redirect, br_redirect, upd_valid, upd_taken;
    logic [31:0] trap_pc, br_pc, upd_pc, upd_target;
    logic [31:0] imem_addr, imem_rdata;
    logic [31:0] PC_pype0, PCp4_pype0, Instraction_pype, PC_Np_pype0;
    logic        is_branch_predict;

    int pass_cnt = 0;
    int total    = 0;

    always #5 clk = ~clk;

    // Instruction memory: addi x1,x0,<addr[11:0]> at every word.
    function automatic logic [31:0] word_at(input logic [31:0] a);
        return {a[11:0], 20'h00093};
    endfunction

    assign imem_rdata = word_at(imem_addr);

    fetch_stage dut (
        .clk               (clk),
        .rst               (rst),
        .keep              (keep),
        .nop               (nop),
        .trap_redirect     (trap_redirect),
        .trap_pc           (trap_pc),
        .br_redirect       (br_redirect),
        .br_pc             (br_pc),
        .upd_valid         (upd_valid),
        .upd_pc            (upd_pc),
        .upd_taken         (upd_taken),
        .upd_target        (upd_target),
        .imem_addr         (imem_addr),
        .imem_rdata        (imem_rdata),
        .PC_pype0          (PC_pype0),
        .PCp4_pype0        (PCp4_pype0),
        .Instraction_pype  (Instraction_pype),
        .is_branch_predict (is_branch_predict),
        .PC_Np_pype0       (PC_Np_pype0)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            pass_cnt++;
            $display("check %s: observed %h expected %h ok", tag, obs, exp);
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock; return at the falling edge for sampling/driving.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic train(input logic [31:0] pc, input logic [31:0] tgt, input logic taken);
        upd_valid = 1'b1; upd_pc = pc; upd_target = tgt; upd_taken = taken;
        step();
        upd_valid = 1'b0; upd_taken = 1'b0;
    endtask

    task automatic redirect_br(input logic [31:0] target);
        br_redirect = 1'b1; br_pc = target;
        step();
        br_redirect = 1'b0;
    endtask

    logic [31:0] exp_bp_npc;
    logic [31:0] exp_bp_taken;
    logic [31:0] exp_bp_addr;

    initial begin
`ifdef FETCH_BPRED_EN
        exp_bp_taken = 32'd1; exp_bp_npc = 32'h100; exp_bp_addr = 32'h100;
`else
        exp_bp_taken = 32'd0; exp_bp_npc = 32'h44;  exp_bp_addr = 32'h44;
`endif
        rst = 1'b1; keep = 0; nop = 0; trap_redirect = 0; br_redirect = 0;
        upd_valid = 0; upd_taken = 0;
        trap_pc = 0; br_pc = 0; upd_pc = 0; upd_target = 0;
        @(negedge clk);
        step();

        // Reset state
        check("rst_addr",  imem_addr, 32'h0);
        check("rst_inst",  Instraction_pype, 32'h13);
        check("rst_pc",    PC_pype0, 32'h0);
        check("rst_bp",    {31'd0, is_branch_predict}, 32'd0);
        check("rst_npc",   PC_Np_pype0, 32'h0);

        // Sequential fetch
        rst = 1'b0;
        step();
        check("seq1_addr", imem_addr, 32'h4);
        check("seq1_pc",   PC_pype0, 32'h0);
        check("seq1_pcp4", PCp4_pype0, 32'h4);
        check("seq1_inst", Instraction_pype, word_at(32'h0));
        check("seq1_npc",  PC_Np_pype0, 32'h4);
        step();
        check("seq2_addr", imem_addr, 32'h8);
        check("seq2_pc",   PC_pype0, 32'h4);
        check("seq2_pcp4", PCp4_pype0, 32'h8);
        step();
        step();
        check("pre_keep_addr", imem_addr, 32'h10);

        // Two-cycle stall at PC 0x10
        keep = 1'b1;
        step();
        step();
        check("keep_addr", imem_addr, 32'h10);
        check("keep_pc",   PC_pype0, 32'hC);
        check("keep_inst", Instraction_pype, word_at(32'hC));
        keep = 1'b0;
        step();
        check("resume_addr", imem_addr, 32'h14);
        check("resume_pc",   PC_pype0, 32'h10);
        check("resume_inst", Instraction_pype, word_at(32'h10));

        // Branch redirect wins over keep
        keep = 1'b1; br_redirect = 1'b1; br_pc = 32'h200;
        step();
        keep = 1'b0; br_redirect = 1'b0;
        check("br_addr", imem_addr, 32'h200);
        check("br_inst", Instraction_pype, 32'h13);
        check("br_bp",   {31'd0, is_branch_predict}, 32'd0);
        check("br_pc0",  PC_pype0, 32'h0);
        step();
        check("br_next_addr", imem_addr, 32'h204);
        check("br_next_pc",   PC_pype0, 32'h200);

        // Trap beats branch redirect
        trap_redirect = 1'b1; trap_pc = 32'h80; br_redirect = 1'b1; br_pc = 32'h200;
        step();
        trap_redirect = 1'b0; br_redirect = 1'b0;
        check("trap_addr", imem_addr, 32'h80);
        check("trap_inst", Instraction_pype, 32'h13);

        // nop flushes IF/ID but PC advances
        step();
        nop = 1'b1;
        step();
        nop = 1'b0;
        check("nop_addr", imem_addr, 32'h88);
        check("nop_inst", Instraction_pype, 32'h13);
        check("nop_pc",   PC_pype0, 32'h0);

        // Predictor training: two taken outcomes at 0x40 -> 0x100
        train(32'h40, 32'h100, 1'b1);
        train(32'h40, 32'h100, 1'b1);
        redirect_br(32'h40);
        check("bp_fetch_addr", imem_addr, 32'h40);
        step();
        check("bp_taken", {31'd0, is_branch_predict}, exp_bp_taken);
        check("bp_npc",   PC_Np_pype0, exp_bp_npc);
        check("bp_addr",  imem_addr, exp_bp_addr);

        // Two not-taken outcomes drop the counter to weakly not-taken
        train(32'h40, 32'h0, 1'b0);
        train(32'h40, 32'h0, 1'b0);
        redirect_br(32'h40);
        step();
        check("bp_nt_taken", {31'd0, is_branch_predict}, 32'd0);
        check("bp_nt_npc",   PC_Np_pype0, 32'h44);

        // Misaligned redirect target is forced to word alignment; pc+4 wraps
        redirect_br(32'hFFFF_FFFE);
        check("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
        step();
        check("wrap_addr1", imem_addr, 32'h0);
        check("wrap_pc",    PC_pype0, 32'hFFFF_FFFC);
        check("wrap_pcp4",  PCp4_pype0, 32'h0);

        // Retrain, then reset mid-stream at 0x30: training must be lost
        train(32'h40, 32'h100, 1'b1);
        train(32'h40, 32'h100, 1'b1);
        redirect_br(32'h30);
        step();
        check("pre_rst_pc", PC_pype0, 32'h30);
        #2 rst = 1'b1;
        #1;
        check("arst_addr", imem_addr, 32'h0);
        check("arst_inst", Instraction_pype, 32'h13);
        check("arst_pc",   PC_pype0, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        step();
        check("post_rst_pc", PC_pype0, 32'h0);
        redirect_br(32'h40);
        step();
        check("post_rst_bp",  {31'd0, is_branch_predict}, 32'd0);
        check("post_rst_npc", PC_Np_pype0, 32'h44);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
